instr_mix_profiler: RTL and testbench

- Downstream consumer of the fetch/decode stage's one-hot outputs: instruction_type[22:0] and instruction_format[4:0].
- Checks each decoded instruction for legality and keeps saturating occurrence counters per type, per format, for the total, and for errors.
- Counters are read back through a one-cycle-latency select/read port, giving the result-output side of the design a per-instruction mix histogram.

---
 rtl/rv_decode_pkg.sv | 63 ++++++
 rtl/sat_counter.sv | 35 +++
 rtl/instr_mix_profiler.sv | 114 +++++++++++
 tb/tb_instr_mix_profiler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared decode definitions: one-hot type/format bit maps, the type-to-format
// class table and the profiler readout indices.
package rv_decode_pkg;

   localparam int unsigned NUM_TYPES = 23;
   localparam int unsigned NUM_FMTS  = 5;
   localparam int unsigned NUM_CNT   = 30;

   // Type bit indices in instruction_type
   localparam int unsigned TYPE_JAL   = 22;
   localparam int unsigned TYPE_JALR  = 21;
   localparam int unsigned TYPE_BEQ   = 20;
   localparam int unsigned TYPE_BNE   = 19;
   localparam int unsigned TYPE_LW    = 18;
   localparam int unsigned TYPE_SW    = 17;
   localparam int unsigned TYPE_ADDI  = 16;
   localparam int unsigned TYPE_SLTI  = 15;
   localparam int unsigned TYPE_SLTIU = 14;
   localparam int unsigned TYPE_XORI  = 13;
   localparam int unsigned TYPE_ORI   = 12;
   localparam int unsigned TYPE_ANDI  = 11;
   localparam int unsigned TYPE_SLLI  = 10;
   localparam int unsigned TYPE_SRLI  = 9;
   localparam int unsigned TYPE_ADD   = 8;
   localparam int unsigned TYPE_SUB   = 7;
   localparam int unsigned TYPE_SLL   = 6;
   localparam int unsigned TYPE_SLT   = 5;
   localparam int unsigned TYPE_SLTU  = 4;
   localparam int unsigned TYPE_XOR   = 3;
   localparam int unsigned TYPE_SRL   = 2;
   localparam int unsigned TYPE_OR    = 1;
   localparam int unsigned TYPE_AND   = 0;

   // Format bit indices in instruction_format
   localparam int unsigned FMT_J = 0;
   localparam int unsigned FMT_B = 1;
   localparam int unsigned FMT_S = 2;
   localparam int unsigned FMT_I = 3;
   localparam int unsigned FMT_R = 4;

   // Format class (bit index) of each type bit; element 22 listed first
   localparam logic [NUM_TYPES-1:0][2:0] TYPE_FMT_LUT = {
      3'(FMT_J),                                               // 22 jal
      3'(FMT_I),                                               // 21 jalr
      3'(FMT_B), 3'(FMT_B),                                    // 20..19 beq, bne
      3'(FMT_I),                                               // 18 lw
      3'(FMT_S),                                               // 17 sw
      3'(FMT_I), 3'(FMT_I), 3'(FMT_I), 3'(FMT_I),              // 16..13
      3'(FMT_I), 3'(FMT_I), 3'(FMT_I), 3'(FMT_I),              // 12..9
      3'(FMT_R), 3'(FMT_R), 3'(FMT_R), 3'(FMT_R), 3'(FMT_R),   // 8..4
      3'(FMT_R), 3'(FMT_R), 3'(FMT_R), 3'(FMT_R)               // 3..0
   };

   // Readout indices: 0..22 are the type counters
   localparam int unsigned SEL_FMT_BASE = 23;
   localparam int unsigned SEL_TOTAL    = 28;
   localparam int unsigned SEL_ERR      = 29;

   function automatic logic [NUM_FMTS-1:0] fmt_onehot(input logic [2:0] fmt_idx);
      return NUM_FMTS'(1) << fmt_idx;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Unsigned counter that holds at all-ones; clear beats increment.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign q = cnt_q;

endmodule

// File: rtl/instr_mix_profiler.sv
// Instruction-mix profiler: registers each decoded sample, classifies it as
// bubble/legal/error and bumps per-type, per-format, total and error counters.
// Counters are read through a registered one-cycle-latency port.
module instr_mix_profiler
   import rv_decode_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [22:0]      instruction_type,
   input  logic [4:0]       instruction_format,
   input  logic             clear,
   input  logic             rd_en,
   input  logic [4:0]       rd_sel,
   output logic             rd_valid,
   output logic [CNT_W-1:0] rd_data,
   output logic             rd_err
);

   // Stage 1 sample registers
   logic                 s1_valid_q, s1_valid_d;
   logic [NUM_TYPES-1:0] s1_type_q, s1_type_d;
   logic [NUM_FMTS-1:0]  s1_fmt_q, s1_fmt_d;

   // Read port registers
   logic             rd_valid_q, rd_valid_d;
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_err_q, rd_err_d;

   logic [NUM_FMTS-1:0]               exp_fmt;
   logic                              is_bubble, is_legal, is_err;
   logic [NUM_CNT-1:0]                inc_vec;
   logic [NUM_CNT-1:0][CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]                  sel_val;

   // Stage 1 next state; clear drops the sample being captured
   always_comb begin
      s1_valid_d = in_valid & ~clear;
      s1_type_d  = instruction_type;
      s1_fmt_d   = instruction_format;
   end

   // Stage 2 classification and per-counter increment strobes
   always_comb begin
      exp_fmt = '0;
      for (int unsigned i = 0; i < NUM_TYPES; i++) begin
         if (s1_type_q[i]) begin
            exp_fmt = exp_fmt | fmt_onehot(TYPE_FMT_LUT[i]);
         end
      end
      is_bubble = (s1_type_q == '0) && (s1_fmt_q == '0);
      // exp_fmt is only meaningful when the type is one-hot, which is checked too
      is_legal  = s1_valid_q && $onehot(s1_type_q) && $onehot(s1_fmt_q) &&
                  (s1_fmt_q == exp_fmt);
      is_err    = s1_valid_q && !is_bubble && !is_legal;

      inc_vec                                      = '0;
      inc_vec[NUM_TYPES-1:0]                       = s1_type_q & {NUM_TYPES{is_legal}};
      inc_vec[SEL_FMT_BASE +: NUM_FMTS]            = s1_fmt_q & {NUM_FMTS{is_legal}};
      inc_vec[SEL_TOTAL]                           = is_legal;
      inc_vec[SEL_ERR]                             = is_err;
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk (clk),
         .rst (rst),
         .inc (inc_vec[g]),
         .clr (clear),
         .q   (cnt[g])
      );
   end

   // Read mux and next read-port state; rd_data holds when idle
   always_comb begin
      sel_val = '0;
      for (int unsigned i = 0; i < NUM_CNT; i++) begin
         if (rd_sel == 5'(i)) begin
            sel_val = cnt[i];
         end
      end
      rd_valid_d = rd_en;
      rd_err_d   = rd_en && (rd_sel > 5'(SEL_ERR));
      rd_data_d  = rd_en ? sel_val : rd_data_q;
   end

   // All pipeline and read-port state
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_type_q  <= '0;
         s1_fmt_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_err_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_type_q  <= s1_type_d;
         s1_fmt_q   <= s1_fmt_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_instr_mix_profiler.sv
// Directed bench for instr_mix_profiler. Two instances share stimulus: a
// 32-bit one and a 4-bit one that exercises saturation. Read requests push
// expected values to a scoreboard that a negedge monitor pops.
module tb_instr_mix_profiler;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [22:0] instruction_type;
   logic [4:0]  instruction_format;
   logic        clear;
   logic        rd_en;
   logic [4:0]  rd_sel;

   logic        rd_valid, rd_err;
   logic [31:0] rd_data;
   logic        rd_valid4, rd_err4;
   logic [3:0]  rd_data4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          sel;
      logic [31:0] e32;
      logic [3:0]  e4;
      logic        eerr;
   } exp_t;

   exp_t sb[$];
   logic en_s = 1'b0;

   instr_mix_profiler u_dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .instruction_type   (instruction_type),
      .instruction_format (instruction_format),
      .clear              (clear),
      .rd_en              (rd_en),
      .rd_sel             (rd_sel),
      .rd_valid           (rd_valid),
      .rd_data            (rd_data),
      .rd_err             (rd_err)
   );

   instr_mix_profiler #(
      .CNT_W (4)
   ) u_dut4 (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .instruction_type   (instruction_type),
      .instruction_format (instruction_format),
      .clear              (clear),
      .rd_en              (rd_en),
      .rd_sel             (rd_sel),
      .rd_valid           (rd_valid4),
      .rd_data            (rd_data4),
      .rd_err             (rd_err4)
   );

   always #5 clk = ~clk;

   // A read accepted at this edge must show rd_valid at the next one
   always @(posedge clk) en_s <= rd_en && !rst;

   // Output monitor: rd_valid framing and scoreboard comparison
   always @(negedge clk) begin
      checks++;
      assert (rd_valid === en_s && rd_valid4 === en_s) else begin
         errors++;
         $error("FAIL rd_valid: got %b/%b want %b", rd_valid, rd_valid4, en_s);
      end
      if (rd_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL unexpected_read: got rd_valid=1 want no pending read");
         end else begin
            exp_t x;
            x = sb.pop_front();
            checks++;
            assert (rd_data === x.e32) else begin
               errors++;
               $error("FAIL rd_data32 sel%0d: got %0d want %0d", x.sel, rd_data, x.e32);
            end
            checks++;
            assert (rd_data4 === x.e4) else begin
               errors++;
               $error("FAIL rd_data4 sel%0d: got %0d want %0d", x.sel, rd_data4, x.e4);
            end
            checks++;
            assert (rd_err === x.eerr && rd_err4 === x.eerr) else begin
               errors++;
               $error("FAIL rd_err sel%0d: got %b/%b want %b", x.sel, rd_err, rd_err4, x.eerr);
            end
         end
      end else begin
         checks++;
         assert (rd_err === 1'b0 && rd_err4 === 1'b0) else begin
            errors++;
            $error("FAIL rd_err_idle: got %b/%b want 0", rd_err, rd_err4);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One read request; 4-bit expectation is the 32-bit one clipped at 15
   task automatic rd(input int sel, input int unsigned e, input logic eerr);
      exp_t x;
      x.sel  = sel;
      x.e32  = e;
      x.e4   = (e > 15) ? 4'd15 : 4'(e);
      x.eerr = eerr;
      sb.push_back(x);
      rd_en  = 1'b1;
      rd_sel = 5'(sel);
      tick();
      rd_en  = 1'b0;
   endtask

   task automatic samp(input logic [22:0] t, input logic [4:0] f);
      in_valid           = 1'b1;
      instruction_type   = t;
      instruction_format = f;
      tick();
      in_valid           = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      rst                = 1'b1;
      in_valid           = 1'b0;
      instruction_type   = '0;
      instruction_format = '0;
      clear              = 1'b0;
      rd_en              = 1'b0;
      rd_sel             = '0;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state of the read port
      checks++;
      assert (rd_data === 32'd0 && rd_data4 === 4'd0) else begin
         errors++;
         $error("FAIL reset_rd_data: got %0d/%0d want 0", rd_data, rd_data4);
      end

      // All counters zero after reset, back-to-back reads, out-of-range selects
      for (int i = 0; i < 30; i++) rd(i, 0, 1'b0);
      rd(30, 0, 1'b1);
      rd(31, 0, 1'b1);

      // jal x3 then add x2, back to back
      repeat (3) samp(23'h400000, 5'h01);
      repeat (2) samp(23'h000100, 5'h10);
      repeat (2) tick();
      rd(22, 3, 1'b0);
      rd(8, 2, 1'b0);
      rd(23, 3, 1'b0);
      rd(27, 2, 1'b0);
      rd(28, 5, 1'b0);
      rd(29, 0, 1'b0);

      // Illegal samples count only as errors; a bubble counts nothing
      do_clear();
      samp(23'h000180, 5'h10);
      samp(23'h020000, 5'h08);
      samp(23'h000000, 5'h02);
      samp(23'h000000, 5'h00);
      repeat (2) tick();
      rd(29, 3, 1'b0);
      rd(28, 0, 1'b0);
      rd(8, 0, 1'b0);
      rd(7, 0, 1'b0);
      rd(17, 0, 1'b0);
      rd(24, 0, 1'b0);
      rd(26, 0, 1'b0);
      rd(27, 0, 1'b0);

      // Latency: sample at edge t, read at t+1 sees old, at t+2 sees new
      samp(23'h010000, 5'h08);
      rd(16, 0, 1'b0);
      rd(16, 1, 1'b0);
      rd(26, 1, 1'b0);

      // Clear discards both the stage-2 update and the in-flight sample
      samp(23'h000100, 5'h10);
      do_clear();
      in_valid           = 1'b1;
      instruction_type   = 23'h000100;
      instruction_format = 5'h10;
      rd(8, 0, 1'b0);
      in_valid = 1'b0;
      rd(28, 0, 1'b0);
      repeat (2) tick();
      rd(8, 1, 1'b0);
      rd(28, 1, 1'b0);
      rd(16, 0, 1'b0);
      rd(29, 0, 1'b0);

      // Saturation on the 4-bit instance: 20 beq then one bne
      do_clear();
      repeat (20) samp(23'h100000, 5'h02);
      repeat (2) tick();
      rd(20, 20, 1'b0);
      rd(24, 20, 1'b0);
      rd(28, 20, 1'b0);
      repeat (2) tick();
      checks++;
      assert (rd_data === 32'd20 && rd_data4 === 4'd15) else begin
         errors++;
         $error("FAIL rd_data_hold: got %0d/%0d want 20/15", rd_data, rd_data4);
      end
      samp(23'h080000, 5'h02);
      repeat (2) tick();
      rd(19, 1, 1'b0);
      rd(24, 21, 1'b0);
      rd(28, 21, 1'b0);
      rd(20, 20, 1'b0);

      // Reset mid-stream loses the in-flight sample
      samp(23'h400000, 5'h01);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      rd(22, 0, 1'b0);
      rd(28, 0, 1'b0);
      rd(20, 0, 1'b0);

      repeat (3) tick();
      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL pending_reads: got %0d outstanding want 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
